// File: rtl/test_capture_buffer_if.sv
// Signal bundle between the capture buffer and its controller or test equipment.
// Latency: none (wires only); all timing lives in test_capture_buffer.
// Backpressure: none; reads are paced by inReadEnable, one pop per cycle at most.
// Ports: probe bus and qualifiers, config write, arm/trigger/abort, read request,
//        live view, read data/strobe, state, sample count, empty and read-error flags.
interface test_capture_buffer_if #(
  parameter int NUM_CH   = 8,
  parameter int CH_WIDTH = 4,
  parameter int DEPTH    = 16,
  parameter int SEL_W    = $clog2(NUM_CH),
  parameter int CNT_W    = $clog2(DEPTH) + 1
);
  logic [NUM_CH*CH_WIDTH-1:0] inProbeData;
  logic [NUM_CH-1:0]          inProbeValid;
  logic                       inCfgWrite;
  logic [SEL_W-1:0]           inCfgSel;
  logic [1:0]                 inCfgMode;
  logic                       inArm;
  logic                       inTrigger;
  logic                       inAbort;
  logic                       inReadEnable;
  logic [CH_WIDTH-1:0]        outLive;
  logic [CH_WIDTH-1:0]        outData;
  logic                       outDataValid;
  logic [1:0]                 outState;
  logic [CNT_W-1:0]           outCount;
  logic                       outEmpty;
  logic                       outReadError;

  modport master (
    output inProbeData, inProbeValid, inCfgWrite, inCfgSel, inCfgMode,
           inArm, inTrigger, inAbort, inReadEnable,
    input  outLive, outData, outDataValid, outState, outCount, outEmpty, outReadError
  );

  modport slave (
    input  inProbeData, inProbeValid, inCfgWrite, inCfgSel, inCfgMode,
           inArm, inTrigger, inAbort, inReadEnable,
    output outLive, outData, outDataValid, outState, outCount, outEmpty, outReadError
  );
endinterface

// File: rtl/test_capture_buffer.sv
// Trigger-driven probe capture: live view of one channel plus a DEPTH-sample burst buffer.
// Latency: live view 1 cycle; a qualified sample is counted 1 cycle later; read data 1 cycle after request.
// Backpressure: none; a full buffer drops further samples, a read while empty or outside DONE flags an error.
// Ports: inClock, inReset (async active-low) plus the slave side of test_capture_buffer_if.
module test_capture_buffer #(
  parameter int NUM_CH   = 8,
  parameter int CH_WIDTH = 4,
  parameter int DEPTH    = 16,
  parameter int SEL_W    = $clog2(NUM_CH),
  parameter int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                 inClock,
  input  logic                 inReset,
  test_capture_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    cfg_sel_q, cfg_sel_d;
  logic [1:0]          cfg_mode_q, cfg_mode_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                have_last_q, have_last_d;
  logic [CH_WIDTH-1:0] last_q, last_d;
  logic [CH_WIDTH-1:0] live_q;
  logic [CH_WIDTH-1:0] rd_data_q;
  logic                rd_vld_q;
  logic                rd_err_q, rd_err_d;
  logic [CH_WIDTH-1:0] mem_q [DEPTH];

  logic [CH_WIDTH-1:0] sel_dat;
  logic                sel_vld;
  logic                changed;
  logic                qual;
  logic                cap_en;
  logic                do_wr;
  logic                do_pop;

  assign sel_dat = bus.inProbeData[int'(cfg_sel_q)*CH_WIDTH +: CH_WIDTH];
  assign sel_vld = bus.inProbeValid[cfg_sel_q];

  // The first sample after arming has nothing to compare against, so it always counts as a change.
  assign changed = !have_last_q || (sel_dat != last_q);

  always_comb begin
    qual = 1'b1;
    case (cfg_mode_q)
      2'd0:    qual = 1'b1;
      2'd1:    qual = sel_vld;
      2'd2:    qual = changed;
      default: qual = sel_vld && changed;
    endcase
  end

  // The trigger cycle itself is already a capture cycle.
  assign cap_en = ((state_q == ST_ARMED) && bus.inTrigger) || (state_q == ST_CAPTURE);

  always_comb begin
    state_d     = state_q;
    cfg_sel_d   = cfg_sel_q;
    cfg_mode_d  = cfg_mode_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    have_last_d = have_last_q;
    last_d      = last_q;
    do_wr       = 1'b0;
    do_pop      = 1'b0;
    rd_err_d    = bus.inReadEnable && ((state_q != ST_DONE) || (count_q == '0));

    // Config is frozen while a capture is pending or running so a burst is never mixed.
    if (bus.inCfgWrite && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
      cfg_sel_d  = ({1'b0, bus.inCfgSel} >= (SEL_W+1)'(NUM_CH)) ? SEL_W'(NUM_CH - 1) : bus.inCfgSel;
      cfg_mode_d = bus.inCfgMode;
    end

    if (bus.inAbort || bus.inArm) begin
      state_d     = bus.inAbort ? ST_IDLE : ST_ARMED;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      have_last_d = 1'b0;
    end else if (cap_en) begin
      state_d = ST_CAPTURE;
      if (qual) begin
        do_wr       = 1'b1;
        wr_ptr_d    = wr_ptr_q + 1'b1;
        count_d     = count_q + 1'b1;
        last_d      = sel_dat;
        have_last_d = 1'b1;
        if (count_q == CNT_W'(DEPTH - 1)) state_d = ST_DONE;
      end
    end else if ((state_q == ST_DONE) && bus.inReadEnable && (count_q != '0)) begin
      do_pop   = 1'b1;
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q - 1'b1;
    end
  end

  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      state_q     <= ST_IDLE;
      cfg_sel_q   <= '0;
      cfg_mode_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      have_last_q <= 1'b0;
      last_q      <= '0;
      live_q      <= '0;
      rd_data_q   <= '0;
      rd_vld_q    <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_sel_q   <= cfg_sel_d;
      cfg_mode_q  <= cfg_mode_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      have_last_q <= have_last_d;
      last_q      <= last_d;
      live_q      <= sel_dat;
      rd_vld_q    <= do_pop;
      rd_err_q    <= rd_err_d;
      if (do_pop) rd_data_q <= mem_q[rd_ptr_q];
    end
  end

  // Storage needs no reset: count_q gates every read of it.
  always_ff @(posedge inClock) begin
    if (do_wr) mem_q[wr_ptr_q] <= sel_dat;
  end

  assign bus.outLive      = live_q;
  assign bus.outData      = rd_data_q;
  assign bus.outDataValid = rd_vld_q;
  assign bus.outState     = state_q;
  assign bus.outCount     = count_q;
  assign bus.outEmpty     = (count_q == '0);
  assign bus.outReadError = rd_err_q;
endmodule

// File: tb/tb_test_capture_buffer.sv
// Bench for test_capture_buffer: directed table, multi-cycle scenarios and a random run against a queue model.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: none; all loops have fixed cycle counts.
module tb_test_capture_buffer;
  localparam int NUM_CH   = 8;
  localparam int CH_WIDTH = 4;
  localparam int DEPTH    = 16;
  localparam int SEL_W    = 3;
  localparam int CNT_W    = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  test_capture_buffer_if #(.NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .DEPTH(DEPTH)) bus();

  test_capture_buffer #(.NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .DEPTH(DEPTH)) dut (
    .inClock (clk),
    .inReset (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.inProbeData  = '0;
    bus.inProbeValid = '0;
    bus.inCfgWrite   = 1'b0;
    bus.inCfgSel     = '0;
    bus.inCfgMode    = '0;
    bus.inArm        = 1'b0;
    bus.inTrigger    = 1'b0;
    bus.inAbort      = 1'b0;
    bus.inReadEnable = 1'b0;
  endtask

  task automatic set_ch(input int k, input logic [3:0] v);
    bus.inProbeData[k*CH_WIDTH +: CH_WIDTH] = v;
  endtask

  function automatic logic [3:0] ch_of(input logic [31:0] p, input int k);
    return p[k*CH_WIDTH +: CH_WIDTH];
  endfunction

  task automatic cfg(input logic [2:0] sel, input logic [1:0] mode);
    bus.inCfgWrite = 1'b1;
    bus.inCfgSel   = sel;
    bus.inCfgMode  = mode;
    tick();
    bus.inCfgWrite = 1'b0;
  endtask

  task automatic arm();
    bus.inArm = 1'b1;
    tick();
    bus.inArm = 1'b0;
  endtask

  // Live-view vectors: a config write only steers the view from the following cycle.
  typedef struct {
    logic        wr;
    logic [2:0]  sel;
    logic [31:0] probe;
    logic [3:0]  exp_live;
  } vec_t;
  vec_t vt[8];

  // Reference model: the buffer is an ordered queue of stored samples.
  int         m_state;
  int         m_sel;
  int         m_mode;
  logic [3:0] m_q[$];
  logic       m_have;
  logic [3:0] m_last;

  initial begin
    clear_inputs();
    tick();
    tick();

    // Outputs while held in reset, then right after release.
    chk("rst_state", 32'(bus.outState), 0);
    chk("rst_empty", 32'(bus.outEmpty), 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_state", 32'(bus.outState), 0);
    chk("idle_count", 32'(bus.outCount), 0);
    chk("idle_empty", 32'(bus.outEmpty), 1);
    chk("idle_live", 32'(bus.outLive), 0);
    chk("idle_data", 32'(bus.outData), 0);
    chk("idle_dv", 32'(bus.outDataValid), 0);
    chk("idle_err", 32'(bus.outReadError), 0);
    bus.inReadEnable = 1'b1;
    tick();
    bus.inReadEnable = 1'b0;
    chk("idle_rd_err", 32'(bus.outReadError), 1);
    chk("idle_rd_dv", 32'(bus.outDataValid), 0);
    tick();
    chk("idle_rd_err_pulse", 32'(bus.outReadError), 0);

    // Table-driven live view and config timing.
    vt[0] = '{1'b1, 3'd3, 32'h8765_4321, 4'h1};
    vt[1] = '{1'b0, 3'd0, 32'h8765_4321, 4'h4};
    vt[2] = '{1'b0, 3'd0, 32'hFEDC_BA98, 4'hB};
    vt[3] = '{1'b1, 3'd7, 32'hFEDC_BA98, 4'hB};
    vt[4] = '{1'b0, 3'd0, 32'hFEDC_BA98, 4'hF};
    vt[5] = '{1'b0, 3'd0, 32'h0F00_0000, 4'h0};
    vt[6] = '{1'b1, 3'd6, 32'h0F00_0000, 4'h0};
    vt[7] = '{1'b0, 3'd0, 32'h0F00_0000, 4'hF};
    for (int i = 0; i < 8; i++) begin
      bus.inCfgWrite  = vt[i].wr;
      bus.inCfgSel    = vt[i].sel;
      bus.inCfgMode   = 2'd0;
      bus.inProbeData = vt[i].probe;
      tick();
      chk($sformatf("vec%0d_live", i), 32'(bus.outLive), 32'(vt[i].exp_live));
    end
    clear_inputs();

    // Mode 0 ramp on channel 3, trigger at value 5, full burst then drain.
    cfg(3'd3, 2'd0);
    arm();
    chk("b_armed", 32'(bus.outState), 1);
    for (int v = 0; v < 5; v++) begin
      set_ch(3, 4'(v));
      tick();
    end
    chk("b_wait_armed", 32'(bus.outState), 1);
    chk("b_wait_count", 32'(bus.outCount), 0);
    set_ch(3, 4'd5);
    bus.inTrigger = 1'b1;
    tick();
    bus.inTrigger = 1'b0;
    chk("b_trig_count", 32'(bus.outCount), 1);
    chk("b_trig_state", 32'(bus.outState), 2);
    for (int i = 1; i < 16; i++) begin
      set_ch(3, 4'(5 + i));
      tick();
      chk($sformatf("b_cap_count%0d", i), 32'(bus.outCount), 32'(i + 1));
    end
    chk("b_done_state", 32'(bus.outState), 3);
    tick();
    chk("b_full_drop", 32'(bus.outCount), 16);
    bus.inReadEnable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("b_rd_dv%0d", i), 32'(bus.outDataValid), 1);
      chk($sformatf("b_rd_dat%0d", i), 32'(bus.outData), 32'((5 + i) % 16));
      chk($sformatf("b_rd_cnt%0d", i), 32'(bus.outCount), 32'(15 - i));
      chk($sformatf("b_rd_empty%0d", i), 32'(bus.outEmpty), (i == 15) ? 1 : 0);
    end
    tick();
    chk("b_over_err", 32'(bus.outReadError), 1);
    chk("b_over_dv", 32'(bus.outDataValid), 0);
    bus.inReadEnable = 1'b0;
    tick();
    chk("b_err_clear", 32'(bus.outReadError), 0);

    // Mode 1: valid on even cycles of a 32-cycle ramp.
    cfg(3'd3, 2'd1);
    arm();
    for (int i = 0; i < 32; i++) begin
      set_ch(3, 4'(i));
      bus.inProbeValid[3] = (i % 2 == 0);
      bus.inTrigger = (i == 0);
      tick();
      chk($sformatf("c_cnt%0d", i), 32'(bus.outCount), 32'(i / 2 + 1));
      chk($sformatf("c_st%0d", i), 32'(bus.outState), (i >= 30) ? 3 : 2);
    end
    bus.inTrigger = 1'b0;
    bus.inProbeValid[3] = 1'b1;
    tick();
    chk("c_full_drop", 32'(bus.outCount), 16);
    bus.inReadEnable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("c_rd%0d", i), 32'(bus.outData), 32'((2 * i) % 16));
    end
    bus.inReadEnable = 1'b0;
    bus.inProbeValid = '0;

    // Mode 2: constant 7 then a single change to 9, valid ignored.
    cfg(3'd3, 2'd2);
    arm();
    set_ch(3, 4'd7);
    bus.inTrigger = 1'b1;
    tick();
    bus.inTrigger = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("d_cnt_7", 32'(bus.outCount), 1);
    set_ch(3, 4'd9);
    for (int i = 0; i < 4; i++) tick();
    chk("d_cnt_9", 32'(bus.outCount), 2);
    chk("d_state", 32'(bus.outState), 2);
    bus.inAbort = 1'b1;
    tick();
    bus.inAbort = 1'b0;
    chk("d_abort_state", 32'(bus.outState), 0);

    // Abort at count 5 with an ignored config write mid-capture.
    cfg(3'd3, 2'd0);
    set_ch(1, 4'hA);
    arm();
    for (int i = 0; i < 5; i++) begin
      set_ch(3, 4'(i + 1));
      bus.inTrigger  = (i == 0);
      bus.inCfgWrite = (i == 2);
      bus.inCfgSel   = 3'd1;
      bus.inCfgMode  = 2'd1;
      tick();
      chk($sformatf("e_cnt%0d", i), 32'(bus.outCount), 32'(i + 1));
      chk($sformatf("e_live%0d", i), 32'(bus.outLive), 32'(i + 1));
    end
    bus.inTrigger  = 1'b0;
    bus.inCfgWrite = 1'b0;
    bus.inAbort    = 1'b1;
    set_ch(3, 4'hC);
    tick();
    bus.inAbort = 1'b0;
    chk("e_abort_state", 32'(bus.outState), 0);
    chk("e_abort_count", 32'(bus.outCount), 0);
    chk("e_abort_empty", 32'(bus.outEmpty), 1);
    chk("e_sel_kept", 32'(bus.outLive), 32'hC);

    // Asynchronous reset at count 10.
    arm();
    for (int i = 0; i < 10; i++) begin
      set_ch(3, 4'(i + 3));
      bus.inTrigger = (i == 0);
      tick();
    end
    bus.inTrigger = 1'b0;
    chk("f_pre_count", 32'(bus.outCount), 10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("f_rst_state", 32'(bus.outState), 0);
    chk("f_rst_count", 32'(bus.outCount), 0);
    chk("f_rst_empty", 32'(bus.outEmpty), 1);
    chk("f_rst_live", 32'(bus.outLive), 0);
    chk("f_rst_data", 32'(bus.outData), 0);
    chk("f_rst_dv", 32'(bus.outDataValid), 0);
    chk("f_rst_err", 32'(bus.outReadError), 0);
    tick();
    set_ch(0, 4'h6);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("f_post_state", 32'(bus.outState), 0);
    chk("f_post_count", 32'(bus.outCount), 0);
    chk("f_post_sel0", 32'(bus.outLive), 32'h6);
    clear_inputs();

    // Random run against the queue model.
    m_state = 0;
    m_sel   = 0;
    m_mode  = 0;
    m_q.delete();
    m_have  = 1'b0;
    m_last  = '0;
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] e_live, e_dat, d;
      logic       e_dv, e_err, v, q;
      bus.inProbeData  = $urandom() & 32'h3333_3333;
      bus.inProbeValid = 8'($urandom());
      bus.inCfgWrite   = ($urandom_range(0, 9) == 0);
      bus.inCfgSel     = 3'($urandom());
      bus.inCfgMode    = 2'($urandom());
      bus.inArm        = ($urandom_range(0, 39) == 0);
      bus.inTrigger    = ($urandom_range(0, 3) == 0);
      bus.inAbort      = ($urandom_range(0, 149) == 0);
      bus.inReadEnable = ($urandom_range(0, 2) == 0);

      e_live = ch_of(bus.inProbeData, m_sel);
      e_dv   = 1'b0;
      e_err  = 1'b0;
      e_dat  = '0;
      if (bus.inReadEnable && (m_state != 3 || m_q.size() == 0)) e_err = 1'b1;
      d = ch_of(bus.inProbeData, m_sel);
      v = bus.inProbeValid[m_sel];
      q = ((m_mode % 2 == 0) || v) && ((m_mode < 2) || !m_have || d != m_last);
      if (bus.inCfgWrite && (m_state == 0 || m_state == 3)) begin
        m_sel  = int'(bus.inCfgSel);
        m_mode = int'(bus.inCfgMode);
      end
      if (bus.inAbort || bus.inArm) begin
        m_state = bus.inAbort ? 0 : 1;
        m_q.delete();
        m_have = 1'b0;
      end else if ((m_state == 1 && bus.inTrigger) || m_state == 2) begin
        m_state = 2;
        if (q) begin
          m_q.push_back(d);
          m_last = d;
          m_have = 1'b1;
          if (m_q.size() == DEPTH) m_state = 3;
        end
      end else if (m_state == 3 && bus.inReadEnable && m_q.size() > 0) begin
        e_dat = m_q.pop_front();
        e_dv  = 1'b1;
      end

      tick();
      chk("r_state", 32'(bus.outState), 32'(m_state));
      chk("r_count", 32'(bus.outCount), 32'(m_q.size()));
      chk("r_empty", 32'(bus.outEmpty), (m_q.size() == 0) ? 1 : 0);
      chk("r_live", 32'(bus.outLive), 32'(e_live));
      chk("r_dv", 32'(bus.outDataValid), 32'(e_dv));
      chk("r_err", 32'(bus.outReadError), 32'(e_err));
      if (e_dv) chk("r_data", 32'(bus.outData), 32'(e_dat));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
